// File: rtl/al_key_buffer_pkg.sv
// Shared definitions for the alarm-clock key buffer: keypad codes, FSM states, BCD limits.
// With AL_KEYBUF_12HR_EN defined, the time validity check follows 12-hour rules.
package al_key_buffer_pkg;

    localparam logic [7:0] KP_0            = 8'h30;
    localparam logic [7:0] KP_1            = 8'h31;
    localparam logic [7:0] KP_2            = 8'h32;
    localparam logic [7:0] KP_3            = 8'h33;
    localparam logic [7:0] KP_4            = 8'h34;
    localparam logic [7:0] KP_5            = 8'h35;
    localparam logic [7:0] KP_6            = 8'h36;
    localparam logic [7:0] KP_7            = 8'h37;
    localparam logic [7:0] KP_8            = 8'h38;
    localparam logic [7:0] KP_9            = 8'h39;
    localparam logic [7:0] KP_STAR         = 8'h2A;
    localparam logic [7:0] KP_MINUS        = 8'h2D;
    localparam logic [7:0] KP_KEY_RELEASED = 8'h00;
    localparam logic [7:0] KP_INVALID      = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_CLEAR  = 2'd2
    } state_t;

    localparam logic [2:0] DIGITS_MAX = 3'd4;
    localparam logic [3:0] LIM_MS_MIN = 4'd5;
`ifdef AL_KEYBUF_12HR_EN
    localparam logic [3:0] LIM_MS_HR_12 = 4'd1;
    localparam logic [3:0] LIM_LS_HR_12 = 4'd2;
`else
    localparam logic [3:0] LIM_MS_HR_24 = 4'd2;
    localparam logic [3:0] LIM_LS_HR_24 = 4'd3;
`endif

    function automatic logic time_valid(input logic [3:0] ms_hr,
                                        input logic [3:0] ls_hr,
                                        input logic [3:0] ms_min,
                                        input logic [2:0] count);
        logic hr_ok;
`ifdef AL_KEYBUF_12HR_EN
        hr_ok = ((ms_hr == 4'd0) && (ls_hr != 4'd0)) ||
                ((ms_hr == LIM_MS_HR_12) && (ls_hr <= LIM_LS_HR_12));
`else
        hr_ok = (ms_hr < LIM_MS_HR_24) ||
                ((ms_hr == LIM_MS_HR_24) && (ls_hr <= LIM_LS_HR_24));
`endif
        return (count != 3'd0) && hr_ok && (ms_min <= LIM_MS_MIN);
    endfunction

endpackage

// File: rtl/al_key_buffer_if.sv
// Controller-facing bundle of the key buffer: strobes and key code in, buffer/alarm view out.
// The pm/alarm_pm pair exists only when AL_KEYBUF_12HR_EN is defined.
interface al_key_buffer_if;
    logic [7:0] key;
    logic       alc_shift;
    logic       load_alarm;
    logic       load_new_time;
    logic       clear;
    logic [3:0] key_ms_hr, key_ls_hr, key_ms_min, key_ls_min;
    logic [2:0] digit_count;
    logic       buffer_valid;
    logic [3:0] alarm_ms_hr, alarm_ls_hr, alarm_ms_min, alarm_ls_min;
    logic       new_time_strobe;
    logic       load_error;
`ifdef AL_KEYBUF_12HR_EN
    logic       pm;
    logic       alarm_pm;
`endif

    modport master (
        output key, alc_shift, load_alarm, load_new_time, clear,
`ifdef AL_KEYBUF_12HR_EN
        output pm,
        input  alarm_pm,
`endif
        input  key_ms_hr, key_ls_hr, key_ms_min, key_ls_min, digit_count, buffer_valid,
        input  alarm_ms_hr, alarm_ls_hr, alarm_ms_min, alarm_ls_min,
        input  new_time_strobe, load_error
    );

    modport slave (
        input  key, alc_shift, load_alarm, load_new_time, clear,
`ifdef AL_KEYBUF_12HR_EN
        input  pm,
        output alarm_pm,
`endif
        output key_ms_hr, key_ls_hr, key_ms_min, key_ls_min, digit_count, buffer_valid,
        output alarm_ms_hr, alarm_ls_hr, alarm_ms_min, alarm_ls_min,
        output new_time_strobe, load_error
    );
endinterface

// File: rtl/al_kp_to_bcd.sv
// Keypad code to BCD digit decoder; also used by the display path.
module al_kp_to_bcd
    import al_key_buffer_pkg::*;
(
    input  logic [7:0] key,
    output logic [3:0] digit,
    output logic       is_digit
);
    assign is_digit = (key >= KP_0) && (key <= KP_9);
    // Digit codes start on a nibble boundary, so the low nibble is the value.
    assign digit    = is_digit ? key[3:0] : 4'd0;
endmodule

// File: rtl/al_key_buffer.sv
// Alarm-clock key buffer: HH:MM digit entry, range check, alarm register, new-time strobe.
// AL_KEYBUF_12HR_EN selects 12-hour validity and adds the latched alarm_pm bit.
module al_key_buffer
    import al_key_buffer_pkg::*;
#(
    parameter logic [7:0] ALARM_RESET_HR  = 8'h00,
    parameter logic [7:0] ALARM_RESET_MIN = 8'h00
) (
    input  logic            clk256,
    input  logic            reset,
    al_key_buffer_if.slave  kb
);
    localparam logic [15:0] ALARM_RESET = {ALARM_RESET_HR, ALARM_RESET_MIN};

    state_t     state_q, state_d;
    logic       shift_prev_q, alarm_prev_q, time_prev_q;
    logic       shift_ev, alarm_ev, time_ev;
    logic       commit_ev, do_shift, buf_zero;
    logic       commit_alarm_q, commit_ok_q;
    logic [3:0] buf_q   [4];
    logic [3:0] alarm_q [4];
    logic [2:0] count_q;
    logic [3:0] key_digit;
    logic       key_is_digit;
    logic       buf_valid;
    logic       in_commit;

    al_kp_to_bcd u_kp_to_bcd (
        .key      (kb.key),
        .digit    (key_digit),
        .is_digit (key_is_digit)
    );

    assign shift_ev = kb.alc_shift     & ~shift_prev_q;
    assign alarm_ev = kb.load_alarm    & ~alarm_prev_q;
    assign time_ev  = kb.load_new_time & ~time_prev_q;

    always_ff @(posedge clk256) begin
        if (reset) begin
            shift_prev_q <= 1'b0;
            alarm_prev_q <= 1'b0;
            time_prev_q  <= 1'b0;
            state_q      <= ST_IDLE;
        end else begin
            shift_prev_q <= kb.alc_shift;
            alarm_prev_q <= kb.load_alarm;
            time_prev_q  <= kb.load_new_time;
            state_q      <= state_d;
        end
    end

    // Clear outranks everything; loads outrank shift; events outside IDLE are dropped.
    always_comb begin
        state_d   = state_q;
        commit_ev = 1'b0;
        do_shift  = 1'b0;
        buf_zero  = 1'b0;
        if (kb.clear) begin
            state_d  = ST_IDLE;
            buf_zero = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (alarm_ev || time_ev) begin
                        commit_ev = 1'b1;
                        state_d   = ST_COMMIT;
                    end else if (shift_ev && key_is_digit) begin
                        do_shift = 1'b1;
                    end
                end
                ST_COMMIT: begin
                    state_d  = ST_CLEAR;
                    buf_zero = 1'b1;
                end
                ST_CLEAR: state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk256) begin
        if (reset) begin
            commit_alarm_q <= 1'b0;
            commit_ok_q    <= 1'b0;
        end else if (commit_ev) begin
            commit_alarm_q <= alarm_ev;
            commit_ok_q    <= buf_valid;
        end
    end

    always_ff @(posedge clk256) begin
        if (reset || buf_zero) begin
            count_q <= 3'd0;
        end else if (do_shift && (count_q != DIGITS_MAX)) begin
            count_q <= count_q + 3'd1;
        end
    end

    // Index 3 is ms_hr, index 0 is ls_min; new digits enter at index 0.
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        always_ff @(posedge clk256) begin
            if (reset || buf_zero) begin
                buf_q[gi] <= 4'd0;
            end else if (do_shift) begin
                if (gi == 0) buf_q[gi] <= key_digit;
                else         buf_q[gi] <= buf_q[(gi == 0) ? 0 : gi - 1];
            end
        end

        always_ff @(posedge clk256) begin
            if (reset) begin
                alarm_q[gi] <= ALARM_RESET[gi*4 +: 4];
            end else if (commit_ev && alarm_ev && buf_valid) begin
                alarm_q[gi] <= buf_q[gi];
            end
        end
    end

`ifdef AL_KEYBUF_12HR_EN
    logic alarm_pm_q;
    always_ff @(posedge clk256) begin
        if (reset) begin
            alarm_pm_q <= 1'b0;
        end else if (commit_ev && alarm_ev && buf_valid) begin
            alarm_pm_q <= kb.pm;
        end
    end
    assign kb.alarm_pm = alarm_pm_q;
`endif

    assign buf_valid = time_valid(buf_q[3], buf_q[2], buf_q[1], count_q);
    assign in_commit = (state_q == ST_COMMIT) && !kb.clear;

    assign kb.key_ms_hr       = buf_q[3];
    assign kb.key_ls_hr       = buf_q[2];
    assign kb.key_ms_min      = buf_q[1];
    assign kb.key_ls_min      = buf_q[0];
    assign kb.digit_count     = count_q;
    assign kb.buffer_valid    = buf_valid;
    assign kb.alarm_ms_hr     = alarm_q[3];
    assign kb.alarm_ls_hr     = alarm_q[2];
    assign kb.alarm_ms_min    = alarm_q[1];
    assign kb.alarm_ls_min    = alarm_q[0];
    assign kb.new_time_strobe = in_commit && !commit_alarm_q && commit_ok_q;
    assign kb.load_error      = in_commit && !commit_ok_q;

endmodule

// File: tb/tb_al_key_buffer.sv
// Directed self-checking bench for al_key_buffer (default 24-hour build).
module tb_al_key_buffer;
    import al_key_buffer_pkg::*;

    logic clk256 = 1'b0;
    logic reset  = 1'b1;
    int   checks = 0;
    int   errors = 0;

    al_key_buffer_if kb ();

    al_key_buffer #(
        .ALARM_RESET_HR  (8'h07),
        .ALARM_RESET_MIN (8'h45)
    ) dut (
        .clk256 (clk256),
        .reset  (reset),
        .kb     (kb)
    );

    always #5 clk256 = ~clk256;

    task automatic step();
        @(posedge clk256);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] buf_val();
        return {kb.key_ms_hr, kb.key_ls_hr, kb.key_ms_min, kb.key_ls_min};
    endfunction

    function automatic logic [15:0] alarm_val();
        return {kb.alarm_ms_hr, kb.alarm_ls_hr, kb.alarm_ms_min, kb.alarm_ls_min};
    endfunction

    task automatic shift_key(input logic [7:0] k);
        kb.key       = k;
        kb.alc_shift = 1'b1;
        step();
        kb.alc_shift = 1'b0;
        step();
        step();
    endtask

    initial begin
        kb.key           = KP_KEY_RELEASED;
        kb.alc_shift     = 1'b0;
        kb.load_alarm    = 1'b0;
        kb.load_new_time = 1'b0;
        kb.clear         = 1'b0;
`ifdef AL_KEYBUF_12HR_EN
        kb.pm            = 1'b0;
`endif
        step();
        step();
        chk("rst_buf",    buf_val(), 16'h0000);
        chk("rst_count",  16'(kb.digit_count), 16'h0);
        chk("rst_alarm",  alarm_val(), 16'h0745);
        chk("rst_valid",  16'(kb.buffer_valid), 16'h0);
        chk("rst_strobe", 16'(kb.new_time_strobe), 16'h0);
        chk("rst_err",    16'(kb.load_error), 16'h0);
        reset = 1'b0;
        step();

        // first shift: one-cycle latency
        kb.key = KP_1; kb.alc_shift = 1'b1;
        step();
        chk("shift_lat_buf",   buf_val(), 16'h0001);
        chk("shift_lat_count", 16'(kb.digit_count), 16'h1);
        kb.alc_shift = 1'b0;
        step(); step();
        shift_key(KP_2); shift_key(KP_3); shift_key(KP_0);
        chk("1230_buf",   buf_val(), 16'h1230);
        chk("1230_count", 16'(kb.digit_count), 16'h4);
        chk("1230_valid", 16'(kb.buffer_valid), 16'h1);

        // valid alarm commit
        kb.load_alarm = 1'b1;
        step();
        chk("la_alarm",  alarm_val(), 16'h1230);
        chk("la_err",    16'(kb.load_error), 16'h0);
        chk("la_strobe", 16'(kb.new_time_strobe), 16'h0);
        chk("la_bufvis", buf_val(), 16'h1230);
        kb.load_alarm = 1'b0;
        step();
        chk("la_clr_buf",   buf_val(), 16'h0000);
        chk("la_clr_count", 16'(kb.digit_count), 16'h0);
        step();

        // 25:00 is rejected
        shift_key(KP_2); shift_key(KP_5); shift_key(KP_0); shift_key(KP_0);
        chk("2500_valid", 16'(kb.buffer_valid), 16'h0);
        kb.load_new_time = 1'b1;
        step();
        chk("bad_err",    16'(kb.load_error), 16'h1);
        chk("bad_strobe", 16'(kb.new_time_strobe), 16'h0);
        kb.load_new_time = 1'b0;
        step();
        chk("bad_err_off", 16'(kb.load_error), 16'h0);
        chk("bad_buf",     buf_val(), 16'h0000);
        chk("bad_alarm",   alarm_val(), 16'h1230);
        step();

        // partial entry 09:30 as new time
        shift_key(KP_9); shift_key(KP_3); shift_key(KP_0);
        chk("0930_buf",   buf_val(), 16'h0930);
        chk("0930_valid", 16'(kb.buffer_valid), 16'h1);
        kb.load_new_time = 1'b1;
        step();
        chk("nt_strobe", 16'(kb.new_time_strobe), 16'h1);
        chk("nt_buf",    buf_val(), 16'h0930);
        chk("nt_err",    16'(kb.load_error), 16'h0);
        kb.load_new_time = 1'b0;
        step();
        chk("nt_strobe_off", 16'(kb.new_time_strobe), 16'h0);
        chk("nt_buf_clr",    buf_val(), 16'h0000);
        step();

        // held shift level gives exactly one shift
        kb.key = KP_7; kb.alc_shift = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("hold_buf",   buf_val(), 16'h0007);
        chk("hold_count", 16'(kb.digit_count), 16'h1);
        kb.alc_shift = 1'b0;
        step();
        shift_key(KP_STAR); shift_key(KP_MINUS); shift_key(KP_INVALID);
        chk("nondig_buf",   buf_val(), 16'h0007);
        chk("nondig_count", 16'(kb.digit_count), 16'h1);

        // roll past four digits, count saturates
        shift_key(KP_1); shift_key(KP_2); shift_key(KP_3); shift_key(KP_4);
        chk("roll_buf",   buf_val(), 16'h1234);
        chk("roll_count", 16'(kb.digit_count), 16'h4);

        // clear beats load_alarm
        kb.clear = 1'b1; kb.load_alarm = 1'b1;
        step();
        chk("clr_buf",   buf_val(), 16'h0000);
        chk("clr_count", 16'(kb.digit_count), 16'h0);
        chk("clr_err",   16'(kb.load_error), 16'h0);
        kb.clear = 1'b0; kb.load_alarm = 1'b0;
        step();
        chk("clr_alarm",  alarm_val(), 16'h1230);
        chk("clr_err2",   16'(kb.load_error), 16'h0);
        chk("clr_strobe", 16'(kb.new_time_strobe), 16'h0);
        step();

        // both loads together: only the alarm commit
        shift_key(KP_0); shift_key(KP_8); shift_key(KP_1); shift_key(KP_5);
        kb.load_alarm = 1'b1; kb.load_new_time = 1'b1;
        step();
        chk("both_alarm",  alarm_val(), 16'h0815);
        chk("both_strobe", 16'(kb.new_time_strobe), 16'h0);
        chk("both_err",    16'(kb.load_error), 16'h0);
        kb.load_alarm = 1'b0; kb.load_new_time = 1'b0;
        step(); step();

        // reset mid-entry
        shift_key(KP_1); shift_key(KP_1);
        chk("mid_buf", buf_val(), 16'h0011);
        reset = 1'b1;
        step();
        chk("mrst_buf",   buf_val(), 16'h0000);
        chk("mrst_count", 16'(kb.digit_count), 16'h0);
        chk("mrst_alarm", alarm_val(), 16'h0745);
        reset = 1'b0;
        step();

        // range boundaries
        shift_key(KP_2); shift_key(KP_3); shift_key(KP_5); shift_key(KP_9);
        chk("2359_valid", 16'(kb.buffer_valid), 16'h1);
        kb.clear = 1'b1; step(); kb.clear = 1'b0; step();
        shift_key(KP_2); shift_key(KP_4); shift_key(KP_0); shift_key(KP_0);
        chk("2400_valid", 16'(kb.buffer_valid), 16'h0);
        kb.clear = 1'b1; step(); kb.clear = 1'b0; step();
        shift_key(KP_6); shift_key(KP_0);
        chk("0060_buf",   buf_val(), 16'h0060);
        chk("0060_valid", 16'(kb.buffer_valid), 16'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
